trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Machine-mode trap/return controller beside the ID stage and its CSR file.
- Arbitrates external interrupt entry, MRET return and WFI sleep. Drains the in-flight pipeline, flushes ID, freezes fetch, then issues one PC redirect together with the matching CSR update strobes.
- Replaces the ad-hoc interrupt/MRET steering in ID with a single sequenced owner of trap-related CSR writes and the PC redirect.

Parameters:
- DRAIN_CYCLES, 2, cycles to wait so older EX/MEM/WB instructions (including CSR writes) retire before redirect; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- stall  in  1  AXI/memory stall; freezes the FSM and drain counter
- interrupt  in  1  external interrupt request, level
- MEIE  in  1  mie.MEIE from CSR file
- MIE  in  1  mstatus.MIE from CSR file
- MRET  in  1  MRET decoded in ID
- WFI  in  1  WFI decoded in ID
- pc_id  in  32  PC of the instruction currently in ID
- mtvec_pc  in  32  mtvec CSR value
- mepc_pc  in  32  mepc CSR value
- fetch_hold  out  1  freeze PC/IF_ID
- flush_id  out  1  force ID instruction to bubble (32'h0)
- redirect_valid  out  1  one-cycle PC override
- redirect_pc  out  32  redirect target
- csr_trap  out  1  one-cycle strobe: mepc<=trap_mepc, MPIE<=MIE, MIE<=0, mcause<=0x8000000B
- trap_mepc  out  32  value written to mepc
- csr_mret  out  1  one-cycle strobe: MIE<=MPIE, MPIE<=1
- busy  out  1  FSM not IDLE

Behaviour:
- States: IDLE, TRAP_DRAIN, TRAP_ENTER, MRET_DRAIN, MRET_EXIT, WFI_SLEEP.
- Outputs are Moore-decoded from registered state; trap_mepc is a register.
- Reset (rst=0 at a clk edge): state=IDLE, counter=0, trap_mepc=0. All outputs 0; redirect_pc=0. Reset mid-sequence aborts the sequence; no strobe is issued.
- stall=1: state, counter and trap_mepc hold. Outputs keep their current values. A redirect/strobe state is not left while stalled, so each strobe is seen exactly once per unstalled cycle.
- Define irq_take = interrupt & MEIE & MIE.
- IDLE priority, highest first:
  - irq_take: trap_mepc<=pc_id, counter<=DRAIN_CYCLES, go TRAP_DRAIN. Any MRET/WFI in ID is discarded and re-executes after return.
  - MRET: counter<=DRAIN_CYCLES, go MRET_DRAIN.
  - WFI: trap_mepc<=pc_id+4, go WFI_SLEEP.
- TRAP_DRAIN: fetch_hold=1, flush_id=1. Counter decrements each cycle; go TRAP_ENTER when counter reaches 1.
- TRAP_ENTER: one cycle, then IDLE.
  - redirect_valid=1, csr_trap=1, flush_id=1.
  - redirect_pc = {mtvec_pc[31:2],2'b00}.
- MRET_DRAIN: fetch_hold=1, flush_id=1, counting as in TRAP_DRAIN. interrupt is ignored. Then go MRET_EXIT.
- MRET_EXIT: one cycle, then IDLE.
  - redirect_valid=1, redirect_pc=mepc_pc, csr_mret=1, flush_id=1.
  - A pending irq is evaluated in the following IDLE cycle.
- WFI_SLEEP: fetch_hold=1, flush_id=1.
  - Wake on interrupt=1 regardless of MEIE/MIE.
  - If irq_take: go TRAP_ENTER directly, since the pipeline is already drained (mepc = WFI pc+4).
  - Else: one-cycle redirect to trap_mepc (pc+4), then IDLE. This reuses TRAP_ENTER decode with csr_trap forced 0, via an internal wake_only flag.
- Latency: a trap sampled at edge N produces redirect_valid in cycle N+DRAIN_CYCLES+1, absent stall.
- Arithmetic: pc_id+4 wraps modulo 2^32 with no carry out. The counter width is 4 bits.
- Simultaneous events: irq_take beats MRET beats WFI. MRET and WFI asserted together is illegal decode; MRET wins.

Optional Feature:
- Macro: TRAP_VECTOR_EN.
- Defined, and mtvec_pc[1:0]==2'b01: interrupt entry redirect_pc = {mtvec_pc[31:2],2'b00} + 32'd44 (4×cause 11).
- Defined, any other mode value: redirect_pc is the base address.
- Undefined: mode bits are ignored and redirect_pc is always the base. The extra adder is absent.

Test Plan:
- DRAIN_CYCLES=2, pc_id=0x100, mtvec=0x8000, MEIE=MIE=1, pulse interrupt at edge 0:
  - fetch_hold=flush_id=1 in cycles 1–2.
  - Cycle 3: redirect_valid=1, redirect_pc=0x8000, csr_trap=1, trap_mepc=0x100.
  - Cycle 4: busy=0.
- MRET in ID, mepc=0x204, interrupt held high during drain:
  - Cycle 3: redirect_pc=0x204, csr_mret=1, csr_trap=0.
  - The trap starts at the next IDLE edge.
- WFI at pc 0x300, MEIE=0, interrupt rises 10 cycles later: single redirect to 0x304, csr_trap=0. With MEIE=MIE=1 instead: redirect 0x8000, csr_trap=1, trap_mepc=0x304.
- stall=1 for 5 cycles during TRAP_DRAIN, then released: redirect delayed by exactly 5 cycles; csr_trap high exactly 1 unstalled cycle.
- rst=0 asserted in TRAP_DRAIN: next cycle all outputs 0, state IDLE, no redirect issued.
- TRAP_VECTOR_EN defined, mtvec=0x8001: redirect_pc=0x802C. Undefined: redirect_pc=0x8000.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET/WFI sequencer: drains, flushes ID, redirects PC.
// Optional macro TRAP_VECTOR_EN enables vectored interrupt entry.
module trap_sequencer #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        interrupt,
    input  logic        MEIE,
    input  logic        MIE,
    input  logic        MRET,
    input  logic        WFI,
    input  logic [31:0] pc_id,
    input  logic [31:0] mtvec_pc,
    input  logic [31:0] mepc_pc,
    output logic        fetch_hold,
    output logic        flush_id,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_trap,
    output logic [31:0] trap_mepc,
    output logic        csr_mret,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        TRAP_DRAIN,
        TRAP_ENTER,
        MRET_DRAIN,
        MRET_EXIT,
        WFI_SLEEP
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] trap_mepc_q, trap_mepc_d;
    logic        wake_only_q, wake_only_d;

    logic        irq_take;
    logic [31:0] base_pc;
    logic [31:0] vec_pc;

    assign irq_take = interrupt & MEIE & MIE;
    assign base_pc  = {mtvec_pc[31:2], 2'b00};

`ifdef TRAP_VECTOR_EN
    assign vec_pc = (mtvec_pc[1:0] == 2'b01) ? base_pc + 32'd44 : base_pc;
`else
    logic mode_unused;
    assign mode_unused = ^mtvec_pc[1:0];
    assign vec_pc      = base_pc;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trap_mepc_d = trap_mepc_q;
        wake_only_d = wake_only_q;
        if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (irq_take) begin
                        trap_mepc_d = pc_id;
                        cnt_d       = DRAIN_INIT;
                        wake_only_d = 1'b0;
                        state_d     = TRAP_DRAIN;
                    end else if (MRET) begin
                        cnt_d   = DRAIN_INIT;
                        state_d = MRET_DRAIN;
                    end else if (WFI) begin
                        trap_mepc_d = pc_id + 32'd4;
                        state_d     = WFI_SLEEP;
                    end
                end
                TRAP_DRAIN, MRET_DRAIN: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = (state_q == TRAP_DRAIN) ?
                                  TRAP_ENTER : MRET_EXIT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                TRAP_ENTER, MRET_EXIT: begin
                    wake_only_d = 1'b0;
                    state_d     = IDLE;
                end
                WFI_SLEEP: begin
                    // Pipeline already drained, so wake goes straight to entry
                    if (interrupt) begin
                        wake_only_d = ~irq_take;
                        state_d     = TRAP_ENTER;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            trap_mepc_q <= 32'd0;
            wake_only_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trap_mepc_q <= trap_mepc_d;
            wake_only_q <= wake_only_d;
        end
    end

    always_comb begin
        fetch_hold     = 1'b0;
        flush_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        csr_trap       = 1'b0;
        csr_mret       = 1'b0;
        unique case (state_q)
            IDLE: ;
            TRAP_DRAIN, MRET_DRAIN, WFI_SLEEP: begin
                fetch_hold = 1'b1;
                flush_id   = 1'b1;
            end
            TRAP_ENTER: begin
                flush_id       = 1'b1;
                redirect_valid = 1'b1;
                csr_trap       = ~wake_only_q;
                redirect_pc    = wake_only_q ? trap_mepc_q : vec_pc;
            end
            MRET_EXIT: begin
                flush_id       = 1'b1;
                redirect_valid = 1'b1;
                csr_mret       = 1'b1;
                redirect_pc    = mepc_pc;
            end
            default: ;
        endcase
    end

    assign trap_mepc = trap_mepc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized bench for trap_sequencer against a countdown reference model.
// Directed test-plan scenarios first, then random traffic.
module tb_trap_sequencer;

    localparam int D = 2;

    localparam int K_NONE  = 0;
    localparam int K_TRAP  = 1;
    localparam int K_MRET  = 2;
    localparam int K_SLEEP = 3;
    localparam int K_WAKE  = 4;

    logic        clk = 1'b0;
    logic        rst, stall, interrupt, MEIE, MIE, MRET, WFI;
    logic [31:0] pc_id, mtvec_pc, mepc_pc;
    logic        fetch_hold, flush_id, redirect_valid;
    logic [31:0] redirect_pc, trap_mepc;
    logic        csr_trap, csr_mret, busy;

    int checks = 0;
    int errors = 0;

    int          m_kind = K_NONE;
    int          m_left = 0;
    logic [31:0] m_mepc = 32'd0;

    trap_sequencer #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .interrupt(interrupt), .MEIE(MEIE), .MIE(MIE),
        .MRET(MRET), .WFI(WFI), .pc_id(pc_id),
        .mtvec_pc(mtvec_pc), .mepc_pc(mepc_pc),
        .fetch_hold(fetch_hold), .flush_id(flush_id),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .csr_trap(csr_trap),
        .trap_mepc(trap_mepc), .csr_mret(csr_mret),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] entry_pc(input logic [31:0] tv);
        logic [31:0] pc;
        pc = tv & ~32'd3;
`ifdef TRAP_VECTOR_EN
        if (tv % 4 == 1) pc = pc + 32'd44;
`endif
        return pc;
    endfunction

    task automatic model_step();
        bit take;
        take = interrupt && MEIE && MIE;
        if (!rst) begin
            m_kind = K_NONE;
            m_left = 0;
            m_mepc = 32'd0;
        end else if (!stall) begin
            case (m_kind)
                K_NONE: begin
                    if (take) begin
                        m_kind = K_TRAP;
                        m_left = D;
                        m_mepc = pc_id;
                    end else if (MRET) begin
                        m_kind = K_MRET;
                        m_left = D;
                    end else if (WFI) begin
                        m_kind = K_SLEEP;
                        m_mepc = pc_id + 32'd4;
                    end
                end
                K_TRAP, K_MRET: begin
                    if (m_left == 0) m_kind = K_NONE;
                    else m_left--;
                end
                K_WAKE: m_kind = K_NONE;
                K_SLEEP: begin
                    if (interrupt) begin
                        m_kind = take ? K_TRAP : K_WAKE;
                        m_left = 0;
                    end
                end
                default: m_kind = K_NONE;
            endcase
        end
    endtask

    task automatic compare_all();
        bit act, redir;
        logic [31:0] rpc;
        act   = (m_kind != K_NONE);
        redir = (m_kind == K_TRAP || m_kind == K_MRET ||
                 m_kind == K_WAKE) && m_left == 0;
        rpc   = 32'd0;
        if (redir) begin
            if (m_kind == K_TRAP) rpc = entry_pc(mtvec_pc);
            else if (m_kind == K_MRET) rpc = mepc_pc;
            else rpc = m_mepc;
        end
        chk("busy", 32'(busy), 32'(act));
        chk("flush_id", 32'(flush_id), 32'(act));
        chk("fetch_hold", 32'(fetch_hold),
            32'(act && !redir));
        chk("redirect_valid", 32'(redirect_valid), 32'(redir));
        chk("redirect_pc", redirect_pc, rpc);
        chk("csr_trap", 32'(csr_trap),
            32'(redir && m_kind == K_TRAP));
        chk("csr_mret", 32'(csr_mret),
            32'(redir && m_kind == K_MRET));
        chk("trap_mepc", trap_mepc, m_mepc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        rst = 1'b1; stall = 1'b0; interrupt = 1'b0;
        MRET = 1'b0; WFI = 1'b0;
    endtask

    task automatic settle();
        quiet();
        for (int i = 0; i < 40 && m_kind != K_NONE; i++) tick();
        chk("settle", 32'(m_kind), 32'(K_NONE));
        tick();
    endtask

    initial begin
        quiet();
        rst = 1'b0; MEIE = 1'b1; MIE = 1'b1;
        pc_id = 32'h100; mtvec_pc = 32'h8000; mepc_pc = 32'h204;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_mepc", trap_mepc, 32'd0);
        rst = 1'b1;
        tick();

        interrupt = 1'b1; tick();
        interrupt = 1'b0;
        chk("tp1_hold1", 32'(fetch_hold), 32'd1);
        tick();
        chk("tp1_hold2", 32'(fetch_hold), 32'd1);
        tick();
        chk("tp1_redir", 32'(redirect_valid), 32'd1);
        chk("tp1_pc", redirect_pc, 32'h8000);
        chk("tp1_trap", 32'(csr_trap), 32'd1);
        chk("tp1_mepc", trap_mepc, 32'h100);
        tick();
        chk("tp1_idle", 32'(busy), 32'd0);
        settle();

        MRET = 1'b1; tick();
        MRET = 1'b0; interrupt = 1'b1;
        tick(); tick();
        chk("tp2_pc", redirect_pc, 32'h204);
        chk("tp2_mret", 32'(csr_mret), 32'd1);
        chk("tp2_trap", 32'(csr_trap), 32'd0);
        tick();
        chk("tp2_idle", 32'(busy), 32'd0);
        tick();
        chk("tp2_retrap", 32'(busy), 32'd1);
        settle();

        pc_id = 32'h300; MEIE = 1'b0;
        WFI = 1'b1; tick();
        WFI = 1'b0;
        repeat (10) tick();
        interrupt = 1'b1; tick();
        interrupt = 1'b0;
        chk("tp3_pc", redirect_pc, 32'h304);
        chk("tp3_trap", 32'(csr_trap), 32'd0);
        settle();
        MEIE = 1'b1;
        WFI = 1'b1; tick();
        WFI = 1'b0;
        repeat (10) tick();
        interrupt = 1'b1; tick();
        interrupt = 1'b0;
        chk("tp3b_pc", redirect_pc, 32'h8000);
        chk("tp3b_trap", 32'(csr_trap), 32'd1);
        chk("tp3b_mepc", trap_mepc, 32'h304);
        settle();

        interrupt = 1'b1; tick();
        interrupt = 1'b0; stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        tick();
        chk("tp4_wait", 32'(redirect_valid), 32'd0);
        tick();
        chk("tp4_redir", 32'(redirect_valid), 32'd1);
        stall = 1'b1;
        tick();
        chk("tp4_stall_trap", 32'(csr_trap), 32'd1);
        stall = 1'b0;
        tick();
        chk("tp4_once", 32'(csr_trap), 32'd0);
        settle();

        interrupt = 1'b1; tick();
        interrupt = 1'b0; rst = 1'b0;
        tick();
        chk("tp5_busy", 32'(busy), 32'd0);
        chk("tp5_redir", 32'(redirect_valid), 32'd0);
        rst = 1'b1;
        repeat (4) tick();
        chk("tp5_noredir", 32'(redirect_valid), 32'd0);
        settle();

        mtvec_pc = 32'h8001;
        interrupt = 1'b1; tick();
        interrupt = 1'b0;
        tick(); tick();
`ifdef TRAP_VECTOR_EN
        chk("tp6_vec", redirect_pc, 32'h802C);
`else
        chk("tp6_vec", redirect_pc, 32'h8000);
`endif
        settle();

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(99) >= 2);
            stall     = ($urandom_range(99) < 15);
            interrupt = ($urandom_range(99) < 10);
            MEIE      = ($urandom_range(99) < 70);
            MIE       = ($urandom_range(99) < 70);
            MRET      = ($urandom_range(99) < 10);
            WFI       = ($urandom_range(99) < 10);
            pc_id     = $urandom();
            if ($urandom_range(9) == 0) pc_id = 32'hFFFF_FFFC;
            mtvec_pc  = $urandom();
            mepc_pc   = $urandom();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
